// File: rtl/mmio_uart_fifo_if.sv
// Register-bus bundle between a CPU IO page decoder and the UART block.
// Ports: i_sel/i_addr/i_wdata/i_wstrb/i_rstrb from the bus master, o_rdata back to it.
// The master modport drives the access signals; the slave modport drives the read data.
interface mmio_uart_fifo_if;
   logic        i_sel;
   logic [1:0]  i_addr;
   logic [31:0] i_wdata;
   logic        i_wstrb;
   logic        i_rstrb;
   logic [31:0] o_rdata;

   modport master (
      output i_sel, i_addr, i_wdata, i_wstrb, i_rstrb,
      input  o_rdata
   );

   modport slave (
      input  i_sel, i_addr, i_wdata, i_wstrb, i_rstrb,
      output o_rdata
   );
endinterface

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped 8N1 UART with TX and RX byte FIFOs and a runtime bit divisor.
// Latency: o_rdata one clock after a read strobe; TX frame starts two clocks after a DATA write.
// Backpressure: none on the bus; DATA writes to a full TX FIFO and RX bytes into a full RX FIFO are dropped.
// Ports: i_clk, i_rst (sync, active-high), bus (slave modport: sel/addr/wdata/wstrb/rstrb/rdata),
//        o_txd serial out, i_rxd async serial in, o_irq = RX FIFO non-empty.
// Option: define MMIO_UART_RX_EN to build the receiver; otherwise i_rxd is ignored and RX status reads 0.
module mmio_uart_fifo #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   mmio_uart_fifo_if.slave bus,
   output logic            o_txd,
   input  logic            i_rxd,
   output logic            o_irq
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0] DIV_RST  = 16'(CLK_FREQ_HZ / BAUD_RATE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_t;

   // ---------------- register access decode ----------------
   logic w_rd, w_wr, w_data_wr, w_data_rd, w_stat_rd, w_div_wr;
   assign w_rd      = bus.i_sel & bus.i_rstrb;
   assign w_wr      = bus.i_sel & bus.i_wstrb;
   assign w_data_wr = w_wr & (bus.i_addr == 2'd0);
   assign w_div_wr  = w_wr & (bus.i_addr == 2'd2);
   assign w_data_rd = w_rd & (bus.i_addr == 2'd0);
   assign w_stat_rd = w_rd & (bus.i_addr == 2'd1);

   logic [15:0] r_div;
   always_ff @(posedge i_clk) begin
      if (i_rst)         r_div <= DIV_RST;
      else if (w_div_wr) r_div <= bus.i_wdata[15:0];
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_tx_wp, r_tx_rp;
   logic [AW:0]   r_tx_cnt;
   logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_busy;
   uart_st_t      r_tx_st;

   assign w_tx_full  = (r_tx_cnt == CNT_FULL);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_push  = w_data_wr & ~w_tx_full;
   assign w_tx_pop   = (r_tx_st == ST_IDLE) & ~w_tx_empty;
   assign w_tx_busy  = ~w_tx_empty | (r_tx_st != ST_IDLE);

   always_ff @(posedge i_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.i_wdata[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + (AW+1)'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - (AW+1)'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   // The divisor is captured at pop time so a DIVISOR write mid-frame only affects later frames.
   logic [15:0] r_tx_div, r_tx_tmr;
   logic [7:0]  r_tx_sh;
   logic [2:0]  r_tx_bit;
   logic        r_txd;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_st  <= ST_IDLE;
         r_tx_div <= '0;
         r_tx_tmr <= '0;
         r_tx_sh  <= '0;
         r_tx_bit <= '0;
         r_txd    <= 1'b1;
      end else begin
         case (r_tx_st)
            ST_IDLE: begin
               r_txd <= 1'b1;
               if (w_tx_pop) begin
                  r_tx_sh  <= r_tx_mem[r_tx_rp];
                  r_tx_div <= r_div;
                  r_tx_tmr <= r_div;
                  r_txd    <= 1'b0;
                  r_tx_st  <= ST_START;
               end
            end
            ST_START: begin
               if (r_tx_tmr == 16'd0) begin
                  r_tx_tmr <= r_tx_div;
                  r_tx_bit <= 3'd0;
                  r_txd    <= r_tx_sh[0];
                  r_tx_st  <= ST_DATA;
               end else begin
                  r_tx_tmr <= r_tx_tmr - 16'd1;
               end
            end
            ST_DATA: begin
               if (r_tx_tmr == 16'd0) begin
                  r_tx_tmr <= r_tx_div;
                  if (r_tx_bit == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_tx_st <= ST_STOP;
                  end else begin
                     // Next bit is sh[1]; shift so sh[0] always holds the bit on the line.
                     r_txd    <= r_tx_sh[1];
                     r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                     r_tx_bit <= r_tx_bit + 3'd1;
                  end
               end else begin
                  r_tx_tmr <= r_tx_tmr - 16'd1;
               end
            end
            ST_STOP: begin
               if (r_tx_tmr == 16'd0) r_tx_st  <= ST_IDLE;
               else                   r_tx_tmr <= r_tx_tmr - 16'd1;
            end
            default: r_tx_st <= ST_IDLE;
         endcase
      end
   end

   assign o_txd = r_txd;

   // ---------------- RX path ----------------
   logic       w_rx_valid, w_rx_ovr, w_rx_ferr;
   logic [7:0] w_rx_head;
   logic       w_unused;

`ifdef MMIO_UART_RX_EN
   logic          r_rx_s1, r_rx_s2, r_rx_s3;
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp;
   logic [AW:0]   r_rx_cnt;
   uart_st_t      r_rx_st;
   logic [15:0]   r_rx_div, r_rx_tmr;
   logic [7:0]    r_rx_sh;
   logic [2:0]    r_rx_bit;
   logic          r_rx_ovr, r_rx_ferr, r_irq;
   logic          w_rx_full, w_rx_done, w_rx_push, w_rx_pop, w_ovr_set, w_ferr_set;

   assign w_rx_full  = (r_rx_cnt == CNT_FULL);
   assign w_rx_valid = (r_rx_cnt != '0);
   assign w_rx_head  = r_rx_mem[r_rx_rp];
   assign w_rx_done  = (r_rx_st == ST_STOP) & (r_rx_tmr == 16'd0);
   assign w_rx_push  = w_rx_done &  r_rx_s2 & ~w_rx_full;
   assign w_ovr_set  = w_rx_done &  r_rx_s2 &  w_rx_full;
   assign w_ferr_set = w_rx_done & ~r_rx_s2;
   assign w_rx_pop   = w_data_rd & w_rx_valid;
   assign w_rx_ovr   = r_rx_ovr;
   assign w_rx_ferr  = r_rx_ferr;
   assign o_irq      = r_irq;
   assign w_unused   = ^bus.i_wdata[31:16];

   always_ff @(posedge i_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_s3   <= 1'b1;
         r_rx_wp   <= '0;
         r_rx_rp   <= '0;
         r_rx_cnt  <= '0;
         r_rx_ovr  <= 1'b0;
         r_rx_ferr <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_rx_s1 <= i_rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + (AW+1)'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - (AW+1)'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
         // Set wins over the read-clear so an error in the read cycle is not lost.
         r_rx_ovr  <= w_ovr_set  | (r_rx_ovr  & ~w_stat_rd);
         r_rx_ferr <= w_ferr_set | (r_rx_ferr & ~w_stat_rd);
         r_irq     <= w_rx_valid;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_st  <= ST_IDLE;
         r_rx_div <= '0;
         r_rx_tmr <= '0;
         r_rx_sh  <= '0;
         r_rx_bit <= '0;
      end else begin
         case (r_rx_st)
            ST_IDLE: begin
               // Falling edge on the synchronised line; first check lands mid start bit.
               if (r_rx_s3 & ~r_rx_s2) begin
                  r_rx_div <= r_div;
                  r_rx_tmr <= r_div >> 1;
                  r_rx_st  <= ST_START;
               end
            end
            ST_START: begin
               if (r_rx_tmr == 16'd0) begin
                  if (r_rx_s2) begin
                     r_rx_st <= ST_IDLE;
                  end else begin
                     r_rx_tmr <= r_rx_div;
                     r_rx_bit <= 3'd0;
                     r_rx_st  <= ST_DATA;
                  end
               end else begin
                  r_rx_tmr <= r_rx_tmr - 16'd1;
               end
            end
            ST_DATA: begin
               if (r_rx_tmr == 16'd0) begin
                  r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                  r_rx_tmr <= r_rx_div;
                  r_rx_bit <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7) r_rx_st <= ST_STOP;
               end else begin
                  r_rx_tmr <= r_rx_tmr - 16'd1;
               end
            end
            ST_STOP: begin
               if (r_rx_tmr == 16'd0) r_rx_st  <= ST_IDLE;
               else                   r_rx_tmr <= r_rx_tmr - 16'd1;
            end
            default: r_rx_st <= ST_IDLE;
         endcase
      end
   end
`else
   assign w_rx_valid = 1'b0;
   assign w_rx_ovr   = 1'b0;
   assign w_rx_ferr  = 1'b0;
   assign w_rx_head  = 8'h00;
   assign o_irq      = 1'b0;
   assign w_unused   = ^{bus.i_wdata[31:16], i_rxd, w_data_rd, w_stat_rd};
`endif

   // ---------------- read data ----------------
   logic [31:0] w_status;
   logic [31:0] r_rdata;
   assign w_status = {22'd0, w_tx_busy, 4'd0, w_rx_ferr, w_rx_ovr, w_rx_valid, w_tx_empty, w_tx_full};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (w_rd) begin
         case (bus.i_addr)
            2'd0:    r_rdata <= {24'd0, (w_rx_valid ? w_rx_head : 8'h00)};
            2'd1:    r_rdata <= w_status;
            2'd2:    r_rdata <= {16'd0, r_div};
            default: r_rdata <= '0;
         endcase
      end
   end

   assign bus.o_rdata = r_rdata;

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed bench for mmio_uart_fifo at 10 MHz / 1 Mbit/s (10 clocks per bit), depth 8.
module tb_mmio_uart_fifo;

   logic clk = 1'b0;
   logic rst;
   logic txd, rxd, irq;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mmio_uart_fifo_if bus_if ();

   mmio_uart_fifo #(
      .CLK_FREQ_HZ (10000000),
      .BAUD_RATE   (1000000),
      .FIFO_DEPTH  (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if),
      .o_txd (txd),
      .i_rxd (rxd),
      .o_irq (irq)
   );

   // All bus tasks are entered on a falling edge and return on a falling edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.i_sel = 1'b1; bus_if.i_wstrb = 1'b1; bus_if.i_addr = a; bus_if.i_wdata = d;
      @(negedge clk);
      bus_if.i_sel = 1'b0; bus_if.i_wstrb = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.i_sel = 1'b1; bus_if.i_rstrb = 1'b1; bus_if.i_addr = a;
      @(negedge clk);
      bus_if.i_sel = 1'b0; bus_if.i_rstrb = 1'b0;
      d = bus_if.o_rdata;
   endtask

   // Waits (bounded) for a start bit, then samples every clock of 10 bit periods of cpb clocks.
   // ok=0 if no start bit, a bit level changes inside its period, or start/stop levels are wrong.
   task automatic capture_frame(input int cpb, input int budget, output logic [7:0] d, output logic ok);
      logic [9:0] bits;
      int n;
      ok = 1'b1; d = 8'h00; n = 0; bits = '0;
      @(negedge clk);
      while (txd !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (txd !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < cpb; c++) begin
            if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) ok = 1'b0;
            @(negedge clk);
         end
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      d = bits[8:1];
   endtask

   task automatic drive_rx_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (10) @(negedge clk);
      end
      rxd = stop;
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b expected 1", txd); end
      total++; if (bus_if.o_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", bus_if.o_rdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
      rst = 1'b0;
      @(negedge clk);
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL reset_status: got %h expected 00000002", r); end
      bus_read(2'd2, r);
      total++; if (r !== 32'h9) begin bad++; $display("FAIL reset_divisor: got %h expected 00000009", r); end
   endtask

   task automatic test_regs();
      logic [31:0] r;
      // Unselected DATA write must not queue anything.
      bus_if.i_sel = 1'b0; bus_if.i_wstrb = 1'b1; bus_if.i_addr = 2'd0; bus_if.i_wdata = 32'h41;
      @(negedge clk);
      bus_if.i_wstrb = 1'b0;
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL nosel_write_status: got %h expected 00000002", r); end
      bus_read(2'd3, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL reserved_read: got %h expected 00000000", r); end
      bus_write(2'd2, 32'hABCD_0009);
      bus_read(2'd2, r);
      total++; if (r !== 32'h9) begin bad++; $display("FAIL divisor_upper: got %h expected 00000009", r); end
      // Unselected read strobe: o_rdata holds.
      bus_if.i_sel = 1'b0; bus_if.i_rstrb = 1'b1; bus_if.i_addr = 2'd1;
      @(negedge clk);
      bus_if.i_rstrb = 1'b0;
      @(negedge clk);
      total++; if (bus_if.o_rdata !== 32'h9) begin bad++; $display("FAIL rdata_hold: got %h expected 00000009", bus_if.o_rdata); end
   endtask

   task automatic test_tx_frame();
      logic [7:0]  d;
      logic        ok;
      logic [31:0] st_mid, r;
      st_mid = '0;
      bus_write(2'd0, 32'h55);
      fork
         capture_frame(10, 300, d, ok);
         begin
            repeat (40) @(negedge clk);
            bus_read(2'd1, st_mid);
         end
      join
      total++; if (ok !== 1'b1 || d !== 8'h55) begin bad++; $display("FAIL tx_55_frame: got ok=%b data=%h expected ok=1 data=55", ok, d); end
      total++; if (st_mid !== 32'h202) begin bad++; $display("FAIL tx_busy_mid: got %h expected 00000202", st_mid); end
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL tx_busy_after: got %h expected 00000002", r); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  cap_d [9];
      logic        cap_ok [9];
      logic [31:0] st;
      logic [7:0]  d;
      logic        ok;
      st = '0;
      fork
         begin : cap_blk
            logic [7:0] dd;
            logic       kk;
            for (int i = 0; i < 9; i++) begin
               capture_frame(10, 300, dd, kk);
               cap_d[i]  = dd;
               cap_ok[i] = kk;
            end
         end
         begin : wr_blk
            bus_if.i_sel = 1'b1; bus_if.i_wstrb = 1'b1; bus_if.i_addr = 2'd0;
            for (int i = 0; i < 10; i++) begin
               bus_if.i_wdata = 32'h10 + i;
               @(negedge clk);
            end
            bus_if.i_sel = 1'b0; bus_if.i_wstrb = 1'b0;
            bus_read(2'd1, st);
         end
      join
      total++; if (st !== 32'h201) begin bad++; $display("FAIL b2b_tx_full: got %h expected 00000201", st); end
      for (int i = 0; i < 9; i++) begin
         total++;
         if (cap_ok[i] !== 1'b1 || cap_d[i] !== 8'(8'h10 + i)) begin
            bad++; $display("FAIL b2b_frame%0d: got ok=%b data=%h expected ok=1 data=%h", i, cap_ok[i], cap_d[i], 8'(8'h10 + i));
         end
      end
      capture_frame(10, 200, d, ok);
      total++; if (ok !== 1'b0) begin bad++; $display("FAIL b2b_extra_frame: got frame data=%h expected none", d); end
   endtask

   task automatic test_divisor_change();
      logic [7:0]  d1, d2;
      logic        ok1, ok2;
      logic [31:0] r;
      fork
         begin
            capture_frame(10, 300, d1, ok1);
            capture_frame(5, 300, d2, ok2);
         end
         begin
            bus_write(2'd0, 32'hC3);
            bus_write(2'd0, 32'h3C);
            repeat (30) @(negedge clk);
            bus_write(2'd2, 32'h4);
         end
      join
      total++; if (ok1 !== 1'b1 || d1 !== 8'hC3) begin bad++; $display("FAIL div_frame1: got ok=%b data=%h expected ok=1 data=c3", ok1, d1); end
      total++; if (ok2 !== 1'b1 || d2 !== 8'h3C) begin bad++; $display("FAIL div_frame2: got ok=%b data=%h expected ok=1 data=3c", ok2, d2); end
      bus_read(2'd2, r);
      total++; if (r !== 32'h4) begin bad++; $display("FAIL div_readback: got %h expected 00000004", r); end
      bus_write(2'd2, 32'h9);
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] r;
      logic [7:0]  d;
      logic        ok;
      bus_write(2'd0, 32'h00);
      bus_write(2'd0, 32'hFF);
      bus_write(2'd2, 32'h4);
      bus_read(2'd2, r);
      total++; if (r !== 32'h4) begin bad++; $display("FAIL midrst_div_pre: got %h expected 00000004", r); end
      repeat (43) @(negedge clk);   // now inside data bit 3 of the 0x00 frame
      total++; if (txd !== 1'b0) begin bad++; $display("FAIL midrst_bit3_level: got %b expected 0", txd); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (txd !== 1'b1) begin bad++; $display("FAIL midrst_txd: got %b expected 1", txd); end
      total++; if (bus_if.o_rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata: got %h expected 0", bus_if.o_rdata); end
      rst = 1'b0;
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL midrst_status: got %h expected 00000002", r); end
      bus_read(2'd2, r);
      total++; if (r !== 32'h9) begin bad++; $display("FAIL midrst_divisor: got %h expected 00000009", r); end
      capture_frame(10, 150, d, ok);
      total++; if (ok !== 1'b0) begin bad++; $display("FAIL midrst_flushed: got frame data=%h expected none", d); end
   endtask

`ifdef MMIO_UART_RX_EN
   task automatic test_rx_basic();
      logic [31:0] r;
      drive_rx_byte(8'hA3, 1'b1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
      bus_read(2'd1, r);
      total++; if (r !== 32'h6) begin bad++; $display("FAIL rx_status_valid: got %h expected 00000006", r); end
      bus_read(2'd0, r);
      total++; if (r !== 32'hA3) begin bad++; $display("FAIL rx_data: got %h expected 000000a3", r); end
      repeat (2) @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
   endtask

   task automatic test_rx_errors();
      logic [31:0] r;
      for (int i = 1; i <= 9; i++) drive_rx_byte(8'(i), 1'b1);
      for (int i = 1; i <= 8; i++) begin
         bus_read(2'd0, r);
         total++; if (r !== 32'(i)) begin bad++; $display("FAIL rx_ovr_data%0d: got %h expected %h", i, r, 32'(i)); end
      end
      bus_read(2'd1, r);
      total++; if (r !== 32'hA) begin bad++; $display("FAIL rx_ovr_sticky: got %h expected 0000000a", r); end
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL rx_ovr_cleared: got %h expected 00000002", r); end
      drive_rx_byte(8'h7E, 1'b0);
      bus_read(2'd1, r);
      total++; if (r !== 32'h12) begin bad++; $display("FAIL rx_ferr_status: got %h expected 00000012", r); end
      bus_read(2'd0, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL rx_ferr_dropped: got %h expected 00000000", r); end
   endtask
`else
   task automatic test_rx_disabled();
      logic [31:0] r;
      drive_rx_byte(8'hA3, 1'b1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL norx_irq: got %b expected 0", irq); end
      bus_read(2'd1, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL norx_status: got %h expected 00000002", r); end
      bus_read(2'd0, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL norx_data: got %h expected 00000000", r); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      bus_if.i_sel = 1'b0; bus_if.i_addr = 2'd0; bus_if.i_wdata = '0;
      bus_if.i_wstrb = 1'b0; bus_if.i_rstrb = 1'b0;
      @(negedge clk);
      test_reset();
      test_regs();
      test_tx_frame();
      test_back_to_back();
      test_divisor_change();
      test_reset_mid_frame();
`ifdef MMIO_UART_RX_EN
      test_rx_basic();
      test_rx_errors();
`else
      test_rx_disabled();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
